// File: rtl/imem_pipelined.sv
// Synchronous instruction memory with a fixed-latency fetch pipeline,
// a run-time program-load port, and fault flagging for bad addresses.
module imem_pipelined #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              fetch_flush,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
);

    localparam int IDX_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imem_pipelined: DEPTH must be a power of 2 in 2..4096");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_lat
        $error("imem_pipelined: LATENCY must be 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] l_idx;
    logic             f_oor;
    logic             l_oor;
    logic             f_fault;
    logic             l_fault;

    assign f_idx = fetch_addr[IDX_W+1:2];
    assign l_idx = load_addr[IDX_W+1:2];

    if (ADDR_W > IDX_W + 2) begin : g_hi
        assign f_oor = |fetch_addr[ADDR_W-1:IDX_W+2];
        assign l_oor = |load_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_nohi
        assign f_oor = 1'b0;
        assign l_oor = 1'b0;
    end

    assign f_fault = (fetch_addr[1:0] != 2'b00) | f_oor;
    assign l_fault = (load_addr[1:0] != 2'b00) | l_oor;

    // A load owns the cycle; the requester must hold its fetch.
    logic accept;
    assign fetch_ready = ~load_en;
    assign accept      = fetch_req & ~load_en;

    always_ff @(posedge clk) begin
        if (load_en && !l_fault) begin
            mem[l_idx] <= load_data;
        end
    end

    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (accept && !f_fault) begin
            rdata_q <= mem[f_idx];
        end
    end

    logic s1_valid_d;
    logic s1_valid_q;
    logic s1_fault_d;
    logic s1_fault_q;
    logic load_err_d;
    logic load_err_q;

    assign s1_valid_d = accept;
    assign s1_fault_d = accept & f_fault;
    assign load_err_d = load_en & l_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_fault_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_fault_q <= s1_fault_d;
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;

    logic              cv [LATENCY];
    logic              cf [LATENCY];
    logic [DATA_W-1:0] ci [LATENCY];

    // The RAM output register has no reset, so stage 1 is masked here.
    assign cv[0] = s1_valid_q;
    assign cf[0] = s1_fault_q;
    assign ci[0] = (s1_valid_q && !s1_fault_q) ? rdata_q : '0;

    for (genvar s = 1; s < LATENCY; s++) begin : g_stage
        logic              v_d;
        logic              v_q;
        logic              f_d;
        logic              f_q;
        logic [DATA_W-1:0] i_d;
        logic [DATA_W-1:0] i_q;

        assign v_d = cv[s-1] & ~fetch_flush;
        assign f_d = v_d & cf[s-1];
        assign i_d = v_d ? ci[s-1] : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                f_q <= 1'b0;
                i_q <= '0;
            end else begin
                v_q <= v_d;
                f_q <= f_d;
                i_q <= i_d;
            end
        end

        assign cv[s] = v_q;
        assign cf[s] = f_q;
        assign ci[s] = i_q;
    end

    assign fetch_valid = cv[LATENCY-1];
    assign fetch_fault = cf[LATENCY-1];
    assign fetch_instr = ci[LATENCY-1];

endmodule

// File: tb/tb_imem_pipelined.sv
// Bench for imem_pipelined: LATENCY 1, 2 and 3 instances share one
// stimulus stream and are checked against a cycle-indexed history model.
module tb_imem_pipelined;

    localparam int DEPTH = 256;
    localparam int MAXC  = 4096;
    localparam int ND    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        fetch_req   = 1'b0;
    logic [31:0] fetch_addr  = '0;
    logic        fetch_flush = 1'b0;
    logic        load_en     = 1'b0;
    logic [31:0] load_addr   = '0;
    logic [31:0] load_data   = '0;

    logic [ND-1:0]       dv;
    logic [ND-1:0]       dflt;
    logic [ND-1:0]       drdy;
    logic [ND-1:0]       derr;
    logic [ND-1:0][31:0] di;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        imem_pipelined #(
            .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
            .LATENCY(k + 1), .INIT_FILE("")
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .fetch_req(fetch_req),
            .fetch_addr(fetch_addr),
            .fetch_ready(drdy[k]),
            .fetch_flush(fetch_flush),
            .fetch_valid(dv[k]),
            .fetch_instr(di[k]),
            .fetch_fault(dflt[k]),
            .load_en(load_en),
            .load_addr(load_addr),
            .load_data(load_data),
            .load_err(derr[k])
        );
    end

    // Model: what happened in each input cycle, plus the memory image.
    logic [31:0] mem_m [DEPTH];
    bit          acc_v [MAXC];
    logic [31:0] acc_i [MAXC];
    bit          acc_f [MAXC];
    bit          fl    [MAXC];
    bit          lerr  [MAXC];
    int          cyc = 0;
    int          rst_mark = 0;

    function automatic bit addr_bad(logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    always @(posedge clk) begin
        if (cyc < MAXC) begin
            acc_v[cyc] <= rst_n && fetch_req && !load_en;
            acc_f[cyc] <= addr_bad(fetch_addr);
            acc_i[cyc] <= addr_bad(fetch_addr) ? 32'h0 : mem_m[(fetch_addr / 4) % DEPTH];
            fl[cyc]    <= fetch_flush;
            lerr[cyc]  <= rst_n && load_en && addr_bad(load_addr);
            if (load_en && !addr_bad(load_addr))
                mem_m[load_addr / 4] <= load_data;
        end
        cyc <= cyc + 1;
    end

    always @(negedge rst_n) rst_mark <= cyc;

    function automatic void model_out(input int lat, output bit v,
                                      output logic [31:0] i, output bit f);
        int c;
        c = cyc - lat;
        v = 1'b0;
        i = '0;
        f = 1'b0;
        if (c >= 0 && c >= rst_mark && acc_v[c]) begin
            v = 1'b1;
            for (int k = c + 1; k < cyc; k++)
                if (fl[k]) v = 1'b0;
            if (v) begin
                i = acc_i[c];
                f = acc_f[c];
            end
        end
    endfunction

    // Hand-computed pins, written only by the stimulus process.
    int          pin_at = -1;
    int          pin_kind = 0;
    int          pin_d = 0;
    bit          pin_v = 1'b0;
    logic [31:0] pin_i = '0;
    bit          pin_f = 1'b0;

    int vec = 0;
    int errs = 0;
    bit started = 1'b0;

    task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s dut%0d (LATENCY=%0d) cycle %0d: got %h expected %h",
                     nm, d, d + 1, cyc, got, exp);
        end
    endtask

    bit          ev;
    logic [31:0] ei;
    bit          ef;
    bit          eerr;

    always @(negedge clk) begin
        if (started && cyc < MAXC) begin
            eerr = (cyc >= 1) && (cyc - 1 >= rst_mark) && lerr[cyc-1];
            for (int d = 0; d < ND; d++) begin
                model_out(d + 1, ev, ei, ef);
                chk("fetch_valid", d, 32'(dv[d]), 32'(ev));
                chk("fetch_instr", d, di[d], ei);
                chk("fetch_fault", d, 32'(dflt[d]), 32'(ef));
                chk("fetch_ready", d, 32'(drdy[d]), 32'(!load_en));
                chk("load_err", d, 32'(derr[d]), 32'(eerr));
            end
            if (cyc == pin_at) begin
                if (pin_kind == 0) begin
                    chk("pin_valid", pin_d, 32'(dv[pin_d]), 32'(pin_v));
                    chk("pin_instr", pin_d, di[pin_d], pin_i);
                    chk("pin_fault", pin_d, 32'(dflt[pin_d]), 32'(pin_f));
                end else if (pin_kind == 1) begin
                    chk("pin_load_err", pin_d, 32'(derr[pin_d]), 32'(pin_v));
                end else begin
                    chk("pin_ready", pin_d, 32'(drdy[pin_d]), 32'(pin_v));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(int kind, int d, bit v, logic [31:0] i, bit f);
        pin_at   = cyc;
        pin_kind = kind;
        pin_d    = d;
        pin_v    = v;
        pin_i    = i;
        pin_f    = f;
    endtask

    logic [31:0] w11;
    logic [31:0] init_w [3];

    initial begin
        init_w[0] = 32'h3c041000;
        init_w[1] = 32'h34840000;
        init_w[2] = 32'h3c011000;
        #2 rst_n = 1'b0;
        started = 1'b1;
        repeat (3) tick();
        pin(0, 2, 1'b0, 32'h0, 1'b0);
        tick();
        pin(1, 0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Program the whole memory through the load port.
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i * 4);
            load_data = (i < 3) ? init_w[i] : $urandom;
            if (i == 11) w11 = load_data;
            tick();
        end
        load_en = 1'b0;
        tick();

        // Back-to-back fetches, LATENCY=1.
        fetch_req = 1'b1; fetch_addr = 32'h0; tick();
        pin(0, 0, 1'b1, 32'h3c041000, 1'b0);
        fetch_addr = 32'h4; tick();
        pin(0, 0, 1'b1, 32'h34840000, 1'b0);
        fetch_addr = 32'h8; tick();
        pin(0, 0, 1'b1, 32'h3c011000, 1'b0);
        fetch_req = 1'b0; tick();
        pin(0, 0, 1'b0, 32'h0, 1'b0);
        tick();

        // Flush with a same-cycle accept, LATENCY=3.
        fetch_req = 1'b1; fetch_addr = 32'h00; tick();
        fetch_addr = 32'h04; tick();
        fetch_addr = 32'h2C; fetch_flush = 1'b1; tick();
        pin(0, 2, 1'b0, 32'h0, 1'b0);
        fetch_req = 1'b0; fetch_flush = 1'b0; tick();
        pin(0, 2, 1'b0, 32'h0, 1'b0);
        tick();
        pin(0, 2, 1'b1, w11, 1'b0);
        fetch_flush = 1'b1; tick();
        fetch_flush = 1'b0; tick();

        // Misaligned and out-of-range fetches.
        fetch_req = 1'b1; fetch_addr = 32'h06; tick();
        pin(0, 0, 1'b1, 32'h0, 1'b1);
        fetch_addr = 32'h400; tick();
        pin(0, 0, 1'b1, 32'h0, 1'b1);
        fetch_req = 1'b0; tick();

        // Load collides with a held fetch, then a faulting load.
        fetch_req = 1'b1; fetch_addr = 32'h10;
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEADBEEF;
        pin(2, 0, 1'b0, 32'h0, 1'b0);
        tick();
        load_en = 1'b0; tick();
        pin(0, 0, 1'b1, 32'hDEADBEEF, 1'b0);
        fetch_req = 1'b0;
        load_en = 1'b1; load_addr = 32'h13; load_data = 32'h12345678; tick();
        pin(1, 0, 1'b1, 32'h0, 1'b0);
        load_en = 1'b0; tick();
        fetch_req = 1'b1; fetch_addr = 32'h10; tick();
        pin(0, 0, 1'b1, 32'hDEADBEEF, 1'b0);
        fetch_req = 1'b0; tick();

        // Asynchronous reset with two fetches in flight, LATENCY=2.
        fetch_req = 1'b1; fetch_addr = 32'h0; tick();
        fetch_addr = 32'h4; tick();
        fetch_req = 1'b0;
        #2 rst_n = 1'b0;
        pin(0, 1, 1'b0, 32'h0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        pin(0, 1, 1'b0, 32'h0, 1'b0);
        tick();
        fetch_req = 1'b1; fetch_addr = 32'h0; tick();
        fetch_req = 1'b0; tick();
        pin(0, 1, 1'b1, 32'h3c041000, 1'b0);
        tick();

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
            end
            if (!(fetch_req && load_en)) begin
                fetch_req = ($urandom_range(0, 99) < 70);
                case ($urandom_range(0, 9))
                    0: fetch_addr = $urandom;
                    1: fetch_addr = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
                    default: fetch_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
                endcase
            end
            load_en = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0: load_addr = $urandom;
                1: load_addr = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h2;
                default: load_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            load_data = $urandom;
            fetch_flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        fetch_req = 1'b0; load_en = 1'b0; fetch_flush = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
